// File: rtl/intr_ctrl.sv
// Four-line vectored interrupt controller: latches rising edges on irq, takes
// the lowest-index enabled line, and sequences PC override on entry and return.
//
// state   | meaning
// IDLE    | no handler running; arbitrates pending & mask when ie = 1
// ENTER   | one cycle: take_irq pulse, vector driven, ret_pc captured
// SERVICE | handler executing; interruption = 1 until reti
// EXIT    | one cycle: restore pulse, PC mux selects ret_pc
module intr_ctrl #(
    parameter int          ADDR_WIDTH    = 10,
    parameter int unsigned VECTOR_BASE   = 'h3F0,
    parameter int unsigned VECTOR_STRIDE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            irq,
    input  logic [3:0]            mask,
    input  logic                  ie,
    input  logic                  reti,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  interruption,
    output logic                  take_irq,
    output logic [ADDR_WIDTH-1:0] vector,
    output logic                  restore,
    output logic [ADDR_WIDTH-1:0] ret_pc,
    output logic [3:0]            pending,
    output logic [1:0]            active_id
);

    typedef enum logic [1:0] {IDLE, ENTER, SERVICE, EXIT} state_t;

    state_t     state, state_nx;
    logic [3:0] irq_q;
    logic [3:0] edges;
    logic [3:0] masked;
    logic [3:0] clr;
    logic [1:0] winner;

    assign edges  = irq & ~irq_q;
    assign masked = pending & mask;
    assign vector = ADDR_WIDTH'(VECTOR_BASE + 32'(active_id) * VECTOR_STRIDE);

    // Fixed priority: scanning downward lets the lowest set index win.
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (masked[i]) winner = 2'(i);
        end
    end

    always_comb begin
        state_nx     = state;
        take_irq     = 1'b0;
        restore      = 1'b0;
        interruption = 1'b0;
        clr          = 4'b0000;
        case (state)
            IDLE: begin
                if (ie && (masked != 4'b0000)) state_nx = ENTER;
            end
            ENTER: begin
                take_irq         = 1'b1;
                clr[active_id]   = 1'b1;
                state_nx         = SERVICE;
            end
            SERVICE: begin
                interruption = 1'b1;
                if (reti) state_nx = EXIT;
            end
            EXIT: begin
                restore  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset aborts a handler immediately; no pulse may leak in that cycle.
        if (reset) begin
            take_irq     = 1'b0;
            restore      = 1'b0;
            interruption = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            irq_q     <= 4'b1111;
            pending   <= 4'b0000;
            active_id <= 2'd0;
            ret_pc    <= '0;
        end else begin
            state   <= state_nx;
            irq_q   <= irq;
            // A new edge in the clearing cycle keeps the request latched.
            pending <= (pending & ~clr) | edges;
            if (state == IDLE && state_nx == ENTER) active_id <= winner;
            if (state == ENTER) ret_pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Table-driven bench for intr_ctrl: each row gives one cycle of inputs and the
// outputs expected in that same cycle; a short hand sequence checks latency.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic [3:0] mask;
    logic       ie;
    logic       reti;
    logic [9:0] pc_next;
    logic       interruption;
    logic       take_irq;
    logic [9:0] vector;
    logic       restore;
    logic [9:0] ret_pc;
    logic [3:0] pending;
    logic [1:0] active_id;

    intr_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .mask         (mask),
        .ie           (ie),
        .reti         (reti),
        .pc_next      (pc_next),
        .interruption (interruption),
        .take_irq     (take_irq),
        .vector       (vector),
        .restore      (restore),
        .ret_pc       (ret_pc),
        .pending      (pending),
        .active_id    (active_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] irq;
        logic [3:0] mask;
        logic       ie;
        logic       reti;
        logic [9:0] pc;
        logic       e_int;
        logic       e_take;
        logic [9:0] e_vec;
        logic       e_rest;
        logic [3:0] e_pend;
        logic [1:0] e_aid;
        logic [9:0] e_ret;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void add(logic rst, logic [3:0] i, logic [3:0] m, logic e, logic r,
                                logic [9:0] pc, logic xi, logic xt, logic [9:0] xv,
                                logic xr, logic [3:0] xp, logic [1:0] xa, logic [9:0] xret);
        vec_t v;
        v.rst = rst; v.irq = i; v.mask = m; v.ie = e; v.reti = r; v.pc = pc;
        v.e_int = xi; v.e_take = xt; v.e_vec = xv; v.e_rest = xr;
        v.e_pend = xp; v.e_aid = xa; v.e_ret = xret;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    endtask

    initial begin
        // rst irq mask ie reti pc | int take vec rest pend aid ret
        // basic take and return on line 2
        add(1, 4'b0000, 4'hF, 1, 0, 10'h055, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000); // 0
        add(0, 4'b0000, 4'hF, 1, 0, 10'h055, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);
        add(0, 4'b0100, 4'hF, 1, 0, 10'h055, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h055, 0, 0, 10'h000, 0, 4'b0100, 0, 10'h000);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h055, 0, 1, 10'h3F8, 0, 4'b0100, 2, 10'h000);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h055, 1, 0, 10'h000, 0, 4'b0000, 2, 10'h055); // 5
        add(0, 4'b0000, 4'hF, 1, 1, 10'h055, 1, 0, 10'h000, 0, 4'b0000, 2, 10'h055);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h055, 0, 0, 10'h000, 1, 4'b0000, 2, 10'h055);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h055, 0, 0, 10'h000, 0, 4'b0000, 2, 10'h055);
        // priority: lines 3 and 1 together
        add(0, 4'b1010, 4'hF, 1, 0, 10'h0AA, 0, 0, 10'h000, 0, 4'b0000, 2, 10'h055);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h0AA, 0, 0, 10'h000, 0, 4'b1010, 2, 10'h055); // 10
        add(0, 4'b0000, 4'hF, 1, 0, 10'h0AA, 0, 1, 10'h3F4, 0, 4'b1010, 1, 10'h055);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h0AA, 1, 0, 10'h000, 0, 4'b1000, 1, 10'h0AA);
        add(0, 4'b0000, 4'hF, 1, 1, 10'h0AA, 1, 0, 10'h000, 0, 4'b1000, 1, 10'h0AA);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h0AA, 0, 0, 10'h000, 1, 4'b1000, 1, 10'h0AA);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h0AA, 0, 0, 10'h000, 0, 4'b1000, 1, 10'h0AA); // 15
        add(0, 4'b0000, 4'hF, 1, 0, 10'h123, 0, 1, 10'h3FC, 0, 4'b1000, 3, 10'h0AA);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h123, 1, 0, 10'h000, 0, 4'b0000, 3, 10'h123);
        add(0, 4'b0000, 4'hF, 1, 1, 10'h123, 1, 0, 10'h000, 0, 4'b0000, 3, 10'h123);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h123, 0, 0, 10'h000, 1, 4'b0000, 3, 10'h123);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h123, 0, 0, 10'h000, 0, 4'b0000, 3, 10'h123); // 20
        // masking, then mask/ie changes during SERVICE
        add(0, 4'b0001, 4'hE, 1, 0, 10'h200, 0, 0, 10'h000, 0, 4'b0000, 3, 10'h123);
        add(0, 4'b0000, 4'hE, 1, 0, 10'h200, 0, 0, 10'h000, 0, 4'b0001, 3, 10'h123);
        add(0, 4'b0000, 4'hE, 1, 0, 10'h200, 0, 0, 10'h000, 0, 4'b0001, 3, 10'h123);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h200, 0, 0, 10'h000, 0, 4'b0001, 3, 10'h123);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h200, 0, 1, 10'h3F0, 0, 4'b0001, 0, 10'h123); // 25
        add(0, 4'b0000, 4'h0, 0, 0, 10'h200, 1, 0, 10'h000, 0, 4'b0000, 0, 10'h200);
        add(0, 4'b0000, 4'h0, 0, 1, 10'h200, 1, 0, 10'h000, 0, 4'b0000, 0, 10'h200);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h200, 0, 0, 10'h000, 1, 4'b0000, 0, 10'h200);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h200, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h200);
        // no nesting, set-wins in ENTER, reti ignored in EXIT and ENTER
        add(0, 4'b0100, 4'hF, 1, 0, 10'h155, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h200); // 30
        add(0, 4'b0000, 4'hF, 1, 0, 10'h155, 0, 0, 10'h000, 0, 4'b0100, 0, 10'h200);
        add(0, 4'b0100, 4'hF, 1, 0, 10'h155, 0, 1, 10'h3F8, 0, 4'b0100, 2, 10'h200);
        add(0, 4'b0001, 4'hF, 1, 0, 10'h155, 1, 0, 10'h000, 0, 4'b0100, 2, 10'h155);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h155, 1, 0, 10'h000, 0, 4'b0101, 2, 10'h155);
        add(0, 4'b0000, 4'hF, 1, 1, 10'h155, 1, 0, 10'h000, 0, 4'b0101, 2, 10'h155); // 35
        add(0, 4'b0000, 4'hF, 1, 0, 10'h155, 0, 0, 10'h000, 1, 4'b0101, 2, 10'h155);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h155, 0, 0, 10'h000, 0, 4'b0101, 2, 10'h155);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h300, 0, 1, 10'h3F0, 0, 4'b0101, 0, 10'h155);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h300, 1, 0, 10'h000, 0, 4'b0100, 0, 10'h300);
        add(0, 4'b0000, 4'hF, 1, 1, 10'h300, 1, 0, 10'h000, 0, 4'b0100, 0, 10'h300); // 40
        add(0, 4'b0000, 4'hF, 1, 1, 10'h300, 0, 0, 10'h000, 1, 4'b0100, 0, 10'h300);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h300, 0, 0, 10'h000, 0, 4'b0100, 0, 10'h300);
        add(0, 4'b0000, 4'hF, 1, 1, 10'h301, 0, 1, 10'h3F8, 0, 4'b0100, 2, 10'h300);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h301, 1, 0, 10'h000, 0, 4'b0000, 2, 10'h301);
        // reset mid-SERVICE aborts without restore
        add(1, 4'b0000, 4'hF, 1, 0, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 2, 10'h301); // 45
        add(0, 4'b0000, 4'hF, 1, 0, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);
        // line held high across reset release
        add(1, 4'b0100, 4'hF, 1, 0, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);
        add(0, 4'b0100, 4'hF, 1, 0, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);
        add(0, 4'b0100, 4'hF, 1, 0, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000); // 50
        add(0, 4'b0100, 4'hF, 1, 0, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);
        // spurious reti in IDLE
        add(0, 4'b0100, 4'hF, 1, 1, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);
        add(0, 4'b0100, 4'hF, 1, 0, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);
        add(0, 4'b0000, 4'hF, 1, 0, 10'h301, 0, 0, 10'h000, 0, 4'b0000, 0, 10'h000);

        reset = 1'b1; irq = 4'b0000; mask = 4'hF; ie = 1'b1; reti = 1'b0; pc_next = 10'h055;
        repeat (2) @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            vec_t e;
            @(posedge clk);
            #1;
            v = vecs[k];
            reset = v.rst; irq = v.irq; mask = v.mask; ie = v.ie; reti = v.reti; pc_next = v.pc;
            exp_q.push_back(v);
            @(negedge clk);
            e = exp_q.pop_front();
            chk("interruption", k, 32'(interruption), 32'(e.e_int));
            chk("take_irq",     k, 32'(take_irq),     32'(e.e_take));
            chk("restore",      k, 32'(restore),      32'(e.e_rest));
            chk("pending",      k, 32'(pending),      32'(e.e_pend));
            chk("active_id",    k, 32'(active_id),    32'(e.e_aid));
            chk("ret_pc",       k, 32'(ret_pc),       32'(e.e_ret));
            if (e.e_take) chk("vector", k, 32'(vector), 32'(e.e_vec));
            if (take_irq || restore) chk("take_restore_excl", k, 32'(take_irq & restore), 32'd0);
        end

        // Hand sequence: minimum latency from an irq[1] edge, then return.
        begin
            int lat;
            bit seen;
            lat = 0; seen = 0;
            @(posedge clk); #1;
            irq = 4'b0010; pc_next = 10'h0AB;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (take_irq) seen = 1;
                else lat++;
                @(posedge clk); #1;
                irq = 4'b0000;
            end
            chk("latency_seen", 100, 32'(seen), 32'd1);
            chk("latency_cycles", 100, 32'(lat), 32'd2);
            @(negedge clk);
            chk("lat_interruption", 101, 32'(interruption), 32'd1);
            chk("lat_ret_pc", 101, 32'(ret_pc), 32'h0AB);
            chk("lat_active_id", 101, 32'(active_id), 32'd1);
            @(posedge clk); #1; reti = 1'b1;
            @(posedge clk); #1; reti = 1'b0;
            seen = 0;
            for (int c = 0; c < 5 && !seen; c++) begin
                @(negedge clk);
                if (restore) seen = 1;
                @(posedge clk); #1;
            end
            chk("restore_seen", 102, 32'(seen), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
